// File: rtl/cvxif_offload_pkg.sv
// Shared types and defaults for the CV-X-IF offload controller.
// Pure declarations: no latency, no backpressure.
// Consumed by cvxif_offload_ctrl and cvxif_id_tracker.
package cvxif_offload_pkg;

    localparam int unsigned DEF_XLEN           = 32;
    localparam int unsigned DEF_NR_IDS         = 4;
    localparam int unsigned DEF_TRANS_ID_BITS  = 3;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

    localparam logic [4:0] EXC_NONE    = 5'd0;
    localparam logic [4:0] EXC_ILLEGAL = 5'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic                         busy;
        logic [DEF_TRANS_ID_BITS-1:0] trans_id;
    } id_entry_t;

endpackage

// File: rtl/cvxif_id_tracker.sv
// Outstanding-id bookkeeping: busy bitmap, tag store, rotating next-free-id search.
// Latency: lookups are combinational; alloc/free/flush take effect at the next edge.
// Backpressure: none internally; has_free_o tells the issuer when ids are exhausted.
module cvxif_id_tracker
    import cvxif_offload_pkg::*;
#(
    parameter  int unsigned NrIds = DEF_NR_IDS,
    localparam int unsigned IdW   = $clog2(NrIds)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         alloc_i,
    input  logic [IdW-1:0]               alloc_id_i,
    input  logic [DEF_TRANS_ID_BITS-1:0] alloc_tag_i,
    input  logic                         free_i,
    input  logic [IdW-1:0]               free_id_i,
    output id_entry_t                    free_entry_o,
    output logic                         free_stale_o,
    output logic                         has_free_o,
    output logic [IdW-1:0]               next_id_o
);

    logic [NrIds-1:0]             busy_q, busy_d;
    logic [NrIds-1:0]             stale_q, stale_d;
    logic [DEF_TRANS_ID_BITS-1:0] tag_q [NrIds];
    logic [DEF_TRANS_ID_BITS-1:0] tag_d [NrIds];
    logic [IdW-1:0]               cnt_q, cnt_d;
    logic [IdW-1:0]               cand;

    assign free_entry_o = '{busy: busy_q[free_id_i], trans_id: tag_q[free_id_i]};
    assign free_stale_o = stale_q[free_id_i];

    // Stale ids were in flight at a flush; their late result is swallowed silently.
    always_comb begin
        busy_d  = busy_q;
        stale_d = stale_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            stale_d = stale_q | busy_q;
            busy_d  = '0;
            cnt_d   = '0;
        end else begin
            if (free_i) begin
                busy_d[free_id_i]  = 1'b0;
                stale_d[free_id_i] = 1'b0;
            end
            if (alloc_i) begin
                busy_d[alloc_id_i]  = 1'b1;
                stale_d[alloc_id_i] = 1'b0;
                tag_d[alloc_id_i]   = alloc_tag_i;
                cnt_d               = alloc_id_i + IdW'(1);
            end
        end
    end

    // Descending scan so the closest free id after the counter wins.
    always_comb begin
        next_id_o  = cnt_q;
        has_free_o = 1'b0;
        cand       = '0;
        for (int k = NrIds - 1; k >= 0; k--) begin
            cand = cnt_q + IdW'(k);
            if (!busy_q[cand]) begin
                next_id_o  = cand;
                has_free_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            stale_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < NrIds; i++) tag_q[i] <= '0;
        end else begin
            busy_q  <= busy_d;
            stale_q <= stale_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: rtl/cvxif_offload_ctrl.sv
// Core-side CV-X-IF initiator: one issue at a time, commit, result/exception writeback.
// Latency: commit same cycle as issue handshake; writeback one cycle after response/result.
// Backpressure: instr_ready_o low without a free id; result_ready low during local wb. Macro: CVXIF_ISSUE_TIMEOUT_EN.
module cvxif_offload_ctrl
    import cvxif_offload_pkg::*;
#(
    parameter  int unsigned XLEN          = DEF_XLEN,
    parameter  int unsigned NrIds         = DEF_NR_IDS,
    parameter  int unsigned TransIdBits   = DEF_TRANS_ID_BITS,
    parameter  int unsigned TimeoutCycles = DEF_TIMEOUT_CYCLES,
    localparam int unsigned IdW           = $clog2(NrIds)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  logic [31:0]            instr_i,
    input  logic [XLEN-1:0]        rs1_i,
    input  logic [XLEN-1:0]        rs2_i,
    input  logic [TransIdBits-1:0] trans_id_i,
    output logic                   x_issue_valid_o,
    input  logic                   x_issue_ready_i,
    output logic [31:0]            x_issue_instr_o,
    output logic [2*XLEN-1:0]      x_issue_rs_o,
    output logic [IdW-1:0]         x_issue_id_o,
    input  logic                   x_accept_i,
    input  logic                   x_writeback_i,
    output logic                   x_commit_valid_o,
    output logic [IdW-1:0]         x_commit_id_o,
    output logic                   x_commit_kill_o,
    input  logic                   x_result_valid_i,
    output logic                   x_result_ready_o,
    input  logic [IdW-1:0]         x_result_id_i,
    input  logic [XLEN-1:0]        x_result_data_i,
    output logic                   wb_valid_o,
    output logic [TransIdBits-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]        wb_data_o,
    output logic                   wb_ex_valid_o,
    output logic                   id_err_o
);

    state_e                 state_q, state_d;
    logic [31:0]            instr_q, instr_d;
    logic [XLEN-1:0]        rs1_q, rs1_d, rs2_q, rs2_d;
    logic [TransIdBits-1:0] tag_q, tag_d;
    logic [IdW-1:0]         id_q, id_d;
    logic                   wb_vld_q, wb_vld_d, local_q, local_d;
    logic                   skid_vld_q, skid_vld_d, id_err_q, id_err_d;
    logic [4:0]             cause_q, cause_d;
    logic [TransIdBits-1:0] wb_tag_q, wb_tag_d, skid_tag_q, skid_tag_d;
    logic [XLEN-1:0]        wb_dat_q, wb_dat_d, skid_dat_q, skid_dat_d;

    logic        out_en, in_issue, issue_hs, res_hs, alloc, local_now, timeout, has_free;
    logic        res_stale;
    logic [IdW-1:0] next_id;
    id_entry_t   res_entry;

    assign out_en    = rst_ni & ~flush_i;
    assign in_issue  = (state_q == ISSUE);
    assign issue_hs  = in_issue & x_issue_ready_i & ~flush_i;
    assign alloc     = issue_hs & x_accept_i & x_writeback_i;
    assign local_now = (issue_hs & ~(x_accept_i & x_writeback_i)) | timeout;

    assign x_result_ready_o = out_en & ~local_q;
    assign res_hs           = x_result_valid_i & x_result_ready_o;

`ifdef CVXIF_ISSUE_TIMEOUT_EN
    localparam int unsigned ToW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;

    assign timeout = in_issue & ~x_issue_ready_i & ~flush_i
                   & (to_cnt_q == ToW'(TimeoutCycles - 1));

    always_comb begin
        to_cnt_d = '0;
        if (in_issue && !x_issue_ready_i && !timeout && !flush_i) to_cnt_d = to_cnt_q + ToW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) to_cnt_q <= '0;
        else         to_cnt_q <= to_cnt_d;
    end
`else
    logic unused_timeout;
    assign timeout        = 1'b0;
    assign unused_timeout = (TimeoutCycles == 0);
`endif

    cvxif_id_tracker #(.NrIds(NrIds)) u_id_tracker (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .alloc_i      (alloc),
        .alloc_id_i   (id_q),
        .alloc_tag_i  (tag_q),
        .free_i       (res_hs),
        .free_id_i    (x_result_id_i),
        .free_entry_o (res_entry),
        .free_stale_o (res_stale),
        .has_free_o   (has_free),
        .next_id_o    (next_id)
    );

    always_comb begin
        state_d         = state_q;
        instr_d         = instr_q;
        rs1_d           = rs1_q;
        rs2_d           = rs2_q;
        tag_d           = tag_q;
        id_d            = id_q;
        instr_ready_o   = 1'b0;
        x_issue_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready_o = out_en & has_free;
                if (instr_valid_i && instr_ready_o) begin
                    instr_d = instr_i;
                    rs1_d   = rs1_i;
                    rs2_d   = rs2_i;
                    tag_d   = trans_id_i;
                    id_d    = next_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                x_issue_valid_o = out_en;
                if (issue_hs || timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            instr_d = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            tag_d   = '0;
            id_d    = '0;
        end
    end

    assign x_issue_instr_o  = out_en ? instr_q : '0;
    assign x_issue_rs_o     = out_en ? {rs2_q, rs1_q} : '0;
    assign x_issue_id_o     = out_en ? id_q : '0;
    assign x_commit_kill_o  = rst_ni & flush_i & in_issue;
    assign x_commit_valid_o = (issue_hs & x_accept_i) | x_commit_kill_o;
    assign x_commit_id_o    = x_commit_valid_o ? id_q : '0;

    // A result colliding with a local wb parks in the skid and drains the next cycle.
    always_comb begin
        wb_vld_d   = 1'b0;
        local_d    = 1'b0;
        cause_d    = EXC_NONE;
        wb_tag_d   = '0;
        wb_dat_d   = '0;
        skid_vld_d = skid_vld_q;
        skid_tag_d = skid_tag_q;
        skid_dat_d = skid_dat_q;
        id_err_d   = res_hs & ~res_entry.busy & ~res_stale;
        if (local_now) begin
            wb_vld_d = 1'b1;
            local_d  = 1'b1;
            wb_tag_d = tag_q;
            if (!(x_accept_i && !timeout)) begin
                cause_d  = EXC_ILLEGAL;
                wb_dat_d = XLEN'(instr_q);
            end
            if (res_hs && res_entry.busy) begin
                skid_vld_d = 1'b1;
                skid_tag_d = res_entry.trans_id;
                skid_dat_d = x_result_data_i;
            end
        end else if (skid_vld_q) begin
            wb_vld_d   = 1'b1;
            wb_tag_d   = skid_tag_q;
            wb_dat_d   = skid_dat_q;
            skid_vld_d = 1'b0;
        end else if (res_hs && res_entry.busy) begin
            wb_vld_d = 1'b1;
            wb_tag_d = res_entry.trans_id;
            wb_dat_d = x_result_data_i;
        end
        if (flush_i) begin
            wb_vld_d   = 1'b0;
            local_d    = 1'b0;
            cause_d    = EXC_NONE;
            wb_tag_d   = '0;
            wb_dat_d   = '0;
            skid_vld_d = 1'b0;
            skid_tag_d = '0;
            skid_dat_d = '0;
            id_err_d   = 1'b0;
        end
    end

    assign wb_valid_o    = out_en & wb_vld_q;
    assign wb_ex_valid_o = out_en & wb_vld_q & (cause_q == EXC_ILLEGAL);
    assign wb_trans_id_o = out_en ? wb_tag_q : '0;
    assign wb_data_o     = out_en ? wb_dat_q : '0;
    assign id_err_o      = out_en & id_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            tag_q      <= '0;
            id_q       <= '0;
            wb_vld_q   <= 1'b0;
            local_q    <= 1'b0;
            cause_q    <= EXC_NONE;
            wb_tag_q   <= '0;
            wb_dat_q   <= '0;
            skid_vld_q <= 1'b0;
            skid_tag_q <= '0;
            skid_dat_q <= '0;
            id_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            tag_q      <= tag_d;
            id_q       <= id_d;
            wb_vld_q   <= wb_vld_d;
            local_q    <= local_d;
            cause_q    <= cause_d;
            wb_tag_q   <= wb_tag_d;
            wb_dat_q   <= wb_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_tag_q <= skid_tag_d;
            skid_dat_q <= skid_dat_d;
            id_err_q   <= id_err_d;
        end
    end

endmodule
